// File: rtl/switch_out_arbiter_pkg.sv
// Shared definitions for the switch output-port arbiter.
// Holds the default flit field layout, the default stall limit and the
// arbiter FSM state encodings.
package switch_out_arbiter_pkg;

  localparam int DATA_SIZE = 8;
  localparam int ADDR_SIZE = 4;

  // A flit carries data, address and one head/type bit.
  function automatic int flit_size(input int data_size, input int addr_size);
    return data_size + addr_size + 1;
  endfunction

  localparam int FLIT_SIZE_DEF   = flit_size(DATA_SIZE, ADDR_SIZE);
  localparam int IN_NUM_DEF      = 5;
  localparam int STALL_LIMIT_DEF = 10000;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/switch_out_arbiter_if.sv
// Bus between the switch inputs / downstream link and one output arbiter.
// slave  : the arbiter side (takes requests and flits, drives grant/pops).
// master : the environment side (switch inputs plus downstream link).
interface switch_out_arbiter_if
  import switch_out_arbiter_pkg::*;
#(
  parameter int IN_NUM    = IN_NUM_DEF,
  parameter int FLIT_SIZE = FLIT_SIZE_DEF
);
  logic [IN_NUM-1:0]           req_i;
  logic [IN_NUM-1:0]           tail_i;
  logic [IN_NUM*FLIT_SIZE-1:0] data_i;
  logic                        wr_ready_in;
  logic [IN_NUM-1:0]           r_ready_o;
  logic [IN_NUM-1:0]           grant_o;
  logic [FLIT_SIZE-1:0]        data_o;
  logic                        wr_ready_out;
  logic [31:0]                 pkts_o;
  logic                        stalled_o;

  modport slave (
    input  req_i, tail_i, data_i, wr_ready_in,
    output r_ready_o, grant_o, data_o, wr_ready_out, pkts_o, stalled_o
  );

  modport master (
    output req_i, tail_i, data_i, wr_ready_in,
    input  r_ready_o, grant_o, data_o, wr_ready_out, pkts_o, stalled_o
  );
endinterface

// File: rtl/switch_out_arbiter_rr_picker.sv
// Round-robin picker: purely combinational.
// req : request vector
// ptr : index where the search starts (wraps modulo N)
// win : one-hot winner, zero when no request is set
module switch_out_arbiter_rr_picker #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win
);

  int   idx_s;
  logic found_s;

  // Scan from ptr upward with wrap; first set request wins.
  always_comb begin
    win     = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < N; i++) begin
      idx_s = int'(ptr) + i;
      if (idx_s >= N) begin
        idx_s = idx_s - N;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s]) begin
        win[idx_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/switch_out_arbiter.sv
// Wormhole output-port arbiter. One input owns the output link from head
// flit to tail flit; owners are chosen round-robin. Counts delivered
// packets and flags a link that made no progress for STALL_LIMIT cycles.
// clk, a_rst : clock, synchronous active-high reset
// bus        : requests/tails/flits in, pops/grant/flit/valid/counters out
module switch_out_arbiter
  import switch_out_arbiter_pkg::*;
#(
  parameter int IN_NUM      = IN_NUM_DEF,
  parameter int FLIT_SIZE   = FLIT_SIZE_DEF,
  parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               a_rst,
  switch_out_arbiter_if.slave bus
);

  localparam int PW = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
  localparam int CW = $clog2(STALL_LIMIT + 1);

  arb_state_e        state_r, state_s;
  logic [PW-1:0]     ptr_r, ptr_s;
  logic [IN_NUM-1:0] grant_r, grant_s;
  logic [31:0]       pkts_r, pkts_s;
  logic [CW-1:0]     cnt_r, cnt_s;

  logic [IN_NUM-1:0]    win_s;
  logic [PW-1:0]        owner_s;
  logic [FLIT_SIZE-1:0] data_s;
  logic                 busy_s, own_req_s, own_tail_s, xfer_s;

  switch_out_arbiter_rr_picker #(.N(IN_NUM), .PW(PW)) u_picker (
    .req (bus.req_i),
    .ptr (ptr_r),
    .win (win_s)
  );

  // Owner index and owner flit selected from the registered one-hot grant.
  always_comb begin
    owner_s = '0;
    data_s  = '0;
    for (int k = 0; k < IN_NUM; k++) begin
      if (grant_r[k]) begin
        owner_s = PW'(k);
        data_s  = bus.data_i[k*FLIT_SIZE +: FLIT_SIZE];
      end else begin
        owner_s = owner_s;
      end
    end
  end

  assign busy_s     = (state_r == ARB_BUSY);
  assign own_req_s  = |(bus.req_i & grant_r);
  assign own_tail_s = |(bus.tail_i & grant_r);
  assign xfer_s     = busy_s & own_req_s & bus.wr_ready_in;

  assign bus.grant_o      = grant_r;
  assign bus.data_o       = data_s;
  assign bus.wr_ready_out = busy_s & own_req_s;
  assign bus.r_ready_o    = busy_s ? (grant_r & bus.req_i & {IN_NUM{bus.wr_ready_in}})
                                   : {IN_NUM{1'b0}};
  assign bus.pkts_o       = pkts_r;
  assign bus.stalled_o    = (cnt_r == CW'(STALL_LIMIT));

  // Next state: arbitrate in IDLE, hold the grant until the tail leaves.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    grant_s = grant_r;
    pkts_s  = pkts_r;
    cnt_s   = cnt_r;
    case (state_r)
      ARB_IDLE: begin
        cnt_s = '0;
        if (|bus.req_i) begin
          grant_s = win_s;
          state_s = ARB_BUSY;
        end else begin
          grant_s = '0;
        end
      end
      ARB_BUSY: begin
        if (xfer_s) begin
          cnt_s = '0;
          if (own_tail_s) begin
            grant_s = '0;
            pkts_s  = pkts_r + 32'd1;
            state_s = ARB_IDLE;
            if (owner_s == PW'(IN_NUM - 1)) begin
              ptr_s = '0;
            end else begin
              ptr_s = owner_s + PW'(1);
            end
          end else begin
            state_s = ARB_BUSY;
          end
        end else if (cnt_r != CW'(STALL_LIMIT)) begin
          // Owner idle or downstream full: count towards the stall flag.
          cnt_s = cnt_r + CW'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = ARB_IDLE;
        grant_s = '0;
        cnt_s   = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (a_rst) begin
      state_r <= ARB_IDLE;
      ptr_r   <= '0;
      grant_r <= '0;
      pkts_r  <= 32'd0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      grant_r <= grant_s;
      pkts_r  <= pkts_s;
      cnt_r   <= cnt_s;
    end
  end

endmodule
